// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline register chain.
package pipe_pkg;

    typedef enum logic {
        PASS = 1'b0,
        HOLD = 1'b1
    } skid_state_t;

    // addi x0, x0, 0: the canonical RV32I no-op used as a bubble payload
    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    function automatic int cnt_width(input int stages);
        return $clog2(stages + 2);
    endfunction

endpackage

// File: rtl/pipe_slice.sv
// One valid+data register slice of the elastic chain.
// Latency: 1 cycle from load to output.
// Backpressure: holds contents whenever load is low; flush clears valid.
module pipe_slice #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= in_valid;
        end
    end

    // payload is qualified by valid, so it needs no reset
    always_ff @(posedge clk) begin
        if (load) begin
            data <= in_data;
        end
    end

endmodule

// File: rtl/elastic_pipe.sv
// Elastic valid/ready register chain of STAGES slices with optional input skid.
// Latency: STAGES cycles from accept to out_valid; skid adds none while passing.
// Backpressure: stalled slices hold, empty slices still load; in_ready drops when full.
module elastic_pipe
    import pipe_pkg::*;
#(
    parameter int               WIDTH  = 64,
    parameter int               STAGES = 1,
    parameter bit               SKID   = 1'b1,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WIDTH-1:0]                in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH-1:0]                out_data,
    input  logic                            flush,
    output logic [cnt_width(STAGES)-1:0]    count
);

    localparam int CW = cnt_width(STAGES);

    logic [STAGES-1:0] vld;
    logic [STAGES:0]   rdy;
    logic [WIDTH-1:0]  dat [STAGES];
    logic              s0_vld;
    logic [WIDTH-1:0]  s0_dat;
    logic              in_xfer;
    logic              out_xfer;

    // a slice can load if it is empty or its successor is taking its entry
    always_comb begin
        rdy[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            rdy[i] = ~vld[i] | rdy[i+1];
        end
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_slice
        if (i == 0) begin : g_head
            pipe_slice #(.WIDTH(WIDTH)) u_slice (
                .clk      (clk),
                .rst_n    (rst_n),
                .load     (rdy[0]),
                .flush    (flush),
                .in_valid (s0_vld),
                .in_data  (s0_dat),
                .valid    (vld[0]),
                .data     (dat[0])
            );
        end else begin : g_body
            pipe_slice #(.WIDTH(WIDTH)) u_slice (
                .clk      (clk),
                .rst_n    (rst_n),
                .load     (rdy[i]),
                .flush    (flush),
                .in_valid (vld[i-1]),
                .in_data  (dat[i-1]),
                .valid    (vld[i]),
                .data     (dat[i])
            );
        end
    end

    assign in_xfer = in_valid & in_ready;

    if (SKID) begin : g_skid
        skid_state_t      state_q;
        skid_state_t      state_d;
        logic [WIDTH-1:0] skid_q;

        // registered ready: only the skid state and flush reach in_ready
        assign in_ready = (state_q == PASS) & ~flush;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= PASS;
            end else if (flush) begin
                state_q <= PASS;
            end else begin
                state_q <= state_d;
            end
        end

        always_ff @(posedge clk) begin
            if (state_q == PASS && in_xfer && !rdy[0]) begin
                skid_q <= in_data;
            end
        end

        always_comb begin
            state_d = state_q;
            s0_vld  = in_xfer;
            s0_dat  = in_data;
            case (state_q)
                PASS: begin
                    if (in_xfer && !rdy[0]) begin
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    s0_vld = 1'b1;
                    s0_dat = skid_q;
                    if (rdy[0]) begin
                        state_d = PASS;
                    end
                end
                default: state_d = PASS;
            endcase
        end
    end else begin : g_noskid
        assign in_ready = rdy[0] & ~flush;
        assign s0_vld   = in_xfer;
        assign s0_dat   = in_data;
    end

    assign out_valid = vld[STAGES-1] & ~flush;
    assign out_data  = out_valid ? dat[STAGES-1] : BUBBLE;
    assign out_xfer  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            count <= count + CW'(in_xfer) - CW'(out_xfer);
        end
    end

endmodule
